// File: rtl/adder_tree_pkg.sv
// Shared definitions for the pipelined adder tree: legality checks, depth and
// per-level width helpers used by the tree, its interface and the testbench.
package adder_tree_pkg;

    localparam int unsigned DEF_NUM_OPS = 8;
    localparam int unsigned DEF_IN_W    = 8;
    localparam int unsigned DEF_TAG_W   = 4;
    // Level-1 adders are fixed 8-bit ripple-carry cells.
    localparam int unsigned RCA_W       = 8;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

    function automatic bit num_ops_legal(input int unsigned n);
        return (n == 2) || (n == 4) || (n == 8) || (n == 16);
    endfunction

    function automatic int unsigned lvl_w(input int unsigned in_w, input int unsigned lvl);
        return in_w + lvl;
    endfunction

endpackage

// File: rtl/adder_tree_8bit_pipe_if.sv
// Operand-set stream in, sum stream out; both directions use valid/ready.
interface adder_tree_8bit_pipe_if
    import adder_tree_pkg::*;
#(
    parameter int unsigned NUM_OPS = DEF_NUM_OPS,
    parameter int unsigned IN_W    = DEF_IN_W,
    parameter int unsigned TAG_W   = DEF_TAG_W
);
    localparam int unsigned OUT_W = lvl_w(IN_W, clog2(NUM_OPS));

    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_OPS*IN_W-1:0] in_ops;
    logic [TAG_W-1:0]        in_tag;
    logic                    out_valid;
    logic                    out_ready;
    logic [OUT_W-1:0]        out_sum;
    logic [TAG_W-1:0]        out_tag;

    modport master (
        output in_valid, in_ops, in_tag, out_ready,
        input  in_ready, out_valid, out_sum, out_tag
    );

    modport slave (
        input  in_valid, in_ops, in_tag, out_ready,
        output in_ready, out_valid, out_sum, out_tag
    );
endinterface

// File: rtl/full_adder_acc.sv
// Single-bit full adder cell used to build the ripple chains.
module full_adder_acc (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/half_adder.sv
// Single-bit half adder cell.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b;
    assign cout = a & b;
endmodule

// File: rtl/rca_8bit.sv
// 8-bit ripple-carry adder: half adder at bit 0, full adders above.
module rca_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum,
    output logic       cout
);
    logic [7:0] carry;

    half_adder u_ha (.a(a[0]), .b(b[0]), .sum(sum[0]), .cout(carry[0]));

    for (genvar i = 1; i < 8; i++) begin : g_fa
        full_adder_acc u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (carry[i-1]),
            .sum (sum[i]),
            .cout(carry[i])
        );
    end

    assign cout = carry[7];
endmodule

// File: rtl/rca_nbit.sv
// W-bit ripple-carry adder, same cell structure as rca_8bit.
module rca_nbit #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W-1:0] carry;

    half_adder u_ha (.a(a[0]), .b(b[0]), .sum(sum[0]), .cout(carry[0]));

    for (genvar i = 1; i < W; i++) begin : g_fa
        full_adder_acc u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (carry[i-1]),
            .sum (sum[i]),
            .cout(carry[i])
        );
    end

    assign cout = carry[W-1];
endmodule

// File: rtl/adder_tree_8bit_pipe.sv
// Pipelined pairwise reduction tree: one register slice per level, each level
// joined to the next by valid/ready so the whole tree absorbs backpressure.
module adder_tree_8bit_pipe
    import adder_tree_pkg::*;
#(
    parameter int unsigned NUM_OPS = DEF_NUM_OPS,
    parameter int unsigned IN_W    = DEF_IN_W,
    parameter int unsigned TAG_W   = DEF_TAG_W
) (
    input logic                   clk,
    input logic                   rst_n,
    adder_tree_8bit_pipe_if.slave bus
);
    localparam int unsigned LVLS  = clog2(NUM_OPS);
    localparam int unsigned OUT_W = lvl_w(IN_W, LVLS);

    if (!num_ops_legal(NUM_OPS)) begin : g_bad_num_ops
        $error("adder_tree_8bit_pipe: NUM_OPS must be 2, 4, 8 or 16");
    end
    if (IN_W != RCA_W) begin : g_bad_in_w
        $error("adder_tree_8bit_pipe: IN_W must be 8");
    end

    logic [LVLS:1]             valid_q;
    logic [LVLS:1]             adv;
    logic [LVLS:1]             vin;
    logic [LVLS:1][TAG_W-1:0]  tag_q;
    logic [LVLS:1][TAG_W-1:0]  tin;

    // Advance chain resolves from the output backwards; in_ready is its tail.
    always_comb begin
        logic nxt;
        adv = '0;
        nxt = bus.out_ready;
        for (int l = LVLS; l >= 1; l--) begin
            adv[l] = !valid_q[l] || nxt;
            nxt    = adv[l];
        end
    end

    always_comb begin
        vin    = '0;
        tin    = '0;
        vin[1] = bus.in_valid;
        tin[1] = bus.in_tag;
        for (int l = 2; l <= LVLS; l++) begin
            vin[l] = valid_q[l-1];
            tin[l] = tag_q[l-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            tag_q   <= '0;
        end else begin
            for (int l = 1; l <= LVLS; l++) begin
                if (adv[l]) begin
                    valid_q[l] <= vin[l];
                    if (vin[l]) tag_q[l] <= tin[l];
                end
            end
        end
    end

    for (genvar l = 1; l <= LVLS; l++) begin : g_lvl
        localparam int unsigned N = NUM_OPS >> l;
        localparam int unsigned W = lvl_w(IN_W, l);

        logic [2*N*(W-1)-1:0] src;
        logic [N*W-1:0]       sum_d;
        logic [N*W-1:0]       sum_q;

        if (l == 1) begin : g_src_in
            assign src = bus.in_ops;
        end else begin : g_src_lvl
            assign src = g_lvl[l-1].sum_q;
        end

        for (genvar p = 0; p < N; p++) begin : g_add
            if (l == 1) begin : g_rca8
                rca_8bit u_rca (
                    .a   (src[(2*p)*(W-1) +: W-1]),
                    .b   (src[(2*p+1)*(W-1) +: W-1]),
                    .sum (sum_d[p*W +: W-1]),
                    .cout(sum_d[p*W + W-1])
                );
            end else begin : g_rcan
                rca_nbit #(.W(W-1)) u_rca (
                    .a   (src[(2*p)*(W-1) +: W-1]),
                    .b   (src[(2*p+1)*(W-1) +: W-1]),
                    .sum (sum_d[p*W +: W-1]),
                    .cout(sum_d[p*W + W-1])
                );
            end
        end

        // Data only loads with a valid set, so idle X operands never reach the regs.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q <= '0;
            end else if (adv[l] && vin[l]) begin
                sum_q <= sum_d;
            end
        end
    end

    assign bus.in_ready  = adv[1];
    assign bus.out_valid = valid_q[LVLS];
    assign bus.out_tag   = tag_q[LVLS];
    assign bus.out_sum   = g_lvl[LVLS].sum_q;

endmodule

// File: tb/tb_adder_tree_8bit_pipe.sv
// Directed bench for the adder tree: default build plus NUM_OPS=2 and 16 builds.
module tb_adder_tree_8bit_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    adder_tree_8bit_pipe_if #(.NUM_OPS(8),  .IN_W(8), .TAG_W(4)) b8 ();
    adder_tree_8bit_pipe_if #(.NUM_OPS(2),  .IN_W(8), .TAG_W(4)) b2 ();
    adder_tree_8bit_pipe_if #(.NUM_OPS(16), .IN_W(8), .TAG_W(4)) b16 ();

    adder_tree_8bit_pipe #(.NUM_OPS(8), .IN_W(8), .TAG_W(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .bus(b8)
    );
    adder_tree_8bit_pipe #(.NUM_OPS(2), .IN_W(8), .TAG_W(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(b2)
    );
    adder_tree_8bit_pipe #(.NUM_OPS(16), .IN_W(8), .TAG_W(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .bus(b16)
    );

    typedef struct {
        logic [63:0] ops;
        logic [3:0]  tag;
        logic [10:0] sum;
    } vec_t;

    typedef struct packed {
        logic [10:0] sum;
        logic [3:0]  tag;
    } exp_t;

    vec_t vecs [6];
    exp_t exp_q [$];
    int   rcv_cyc [$];
    int   errors = 0;
    int   checks = 0;
    int   rcv, acc, extra, cyc, lat, stale;
    bit   sb_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] ref_sum8(input logic [63:0] ops);
        logic [10:0] s;
        s = '0;
        for (int k = 0; k < 8; k++) s = s + 11'(ops[k*8 +: 8]);
        return s;
    endfunction

    function automatic logic [7:0] bp_byte(input int k);
        return 8'(17 * (k + 1));
    endfunction

    // One cycle on the 8-op DUT: score transfers that happen at the next edge.
    task automatic tick();
        #1;
        if (sb_en) begin
            if (b8.out_valid && b8.out_ready) begin
                if (exp_q.size() == 0) begin
                    extra++;
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_sum", 32'(b8.out_sum), 32'(e.sum));
                    check("sb_tag", 32'(b8.out_tag), 32'(e.tag));
                    rcv++;
                    rcv_cyc.push_back(cyc);
                end
            end
            if (b8.in_valid && b8.in_ready) begin
                exp_q.push_back({ref_sum8(b8.in_ops), b8.in_tag});
                acc++;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] ops16;
        logic [11:0]  exp16 [2];
        logic [3:0]   tag16 [2];
        logic [15:0]  ops2 [2];
        logic [8:0]   exp2 [2];

        vecs[0] = '{ops: 64'h0807060504030201, tag: 4'h5, sum: 11'h024};
        vecs[1] = '{ops: 64'hFFFFFFFFFFFFFFFF, tag: 4'hA, sum: 11'h7F8};
        vecs[2] = '{ops: 64'h0000000000000000, tag: 4'h0, sum: 11'h000};
        vecs[3] = '{ops: 64'h8080808080808080, tag: 4'h3, sum: 11'h400};
        vecs[4] = '{ops: 64'h00FF00FF00FF00FF, tag: 4'hC, sum: 11'h3FC};
        vecs[5] = '{ops: 64'hF0DEBC9A78563412, tag: 4'h9, sum: 11'h438};

        rst_n = 1'b0;
        b8.in_valid = 0;  b8.in_ops = '0;  b8.in_tag = '0;  b8.out_ready = 1;
        b2.in_valid = 0;  b2.in_ops = '0;  b2.in_tag = '0;  b2.out_ready = 1;
        b16.in_valid = 0; b16.in_ops = '0; b16.in_tag = '0; b16.out_ready = 1;

        // Reset state
        #12;
        check("rst_out_valid", 32'(b8.out_valid), 0);
        check("rst_out_sum", 32'(b8.out_sum), 0);
        check("rst_out_tag", 32'(b8.out_tag), 0);
        check("rst_out_valid_n2", 32'(b2.out_valid), 0);
        check("rst_out_sum_n16", 32'(b16.out_sum), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(b8.in_ready), 1);
        check("rst_in_ready_n2", 32'(b2.in_ready), 1);
        check("rst_in_ready_n16", 32'(b16.in_ready), 1);

        // Single sets from the table: latency, sum and tag
        for (int i = 0; i < 6; i++) begin
            b8.in_valid = 1;
            b8.in_ops   = vecs[i].ops;
            b8.in_tag   = vecs[i].tag;
            #1;
            check("vec_in_ready", 32'(b8.in_ready), 1);
            @(posedge clk);
            #1;
            b8.in_valid = 0;
            b8.in_ops   = 'x;
            b8.in_tag   = 'x;
            lat = 1;
            while (!b8.out_valid && lat < 10) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check("vec_latency", 32'(lat), 3);
            check("vec_sum", 32'(b8.out_sum), 32'(vecs[i].sum));
            check("vec_tag", 32'(b8.out_tag), 32'(vecs[i].tag));
            @(posedge clk);
            #1;
            check("vec_drained", 32'(b8.out_valid), 0);
        end

        // 20 back-to-back random sets with out_ready held high
        sb_en = 1; rcv = 0; acc = 0; extra = 0; cyc = 0;
        rcv_cyc.delete();
        for (int i = 0; i < 20; i++) begin
            b8.in_valid = 1;
            b8.in_ops   = {$urandom, $urandom};
            b8.in_tag   = 4'(i);
            tick();
        end
        b8.in_valid = 0;
        b8.in_ops   = 'x;
        while (rcv < 20 && cyc < 60) tick();
        check("b2b_accepted", 32'(acc), 20);
        check("b2b_results", 32'(rcv), 20);
        check("b2b_extra", 32'(extra), 0);
        if (rcv_cyc.size() > 0) begin
            check("b2b_first_cycle", 32'(rcv_cyc[0]), 3);
            check("b2b_span", 32'(rcv_cyc[rcv_cyc.size()-1] - rcv_cyc[0]), 19);
        end

        // Backpressure: out_ready low for 6 cycles with in_valid held high
        rcv = 0; acc = 0; extra = 0; cyc = 0;
        b8.out_ready = 0;
        for (int i = 0; i < 6; i++) begin
            b8.in_valid = 1;
            b8.in_ops   = {8{bp_byte(acc)}};
            b8.in_tag   = 4'(acc + 1);
            tick();
        end
        check("bp_accepted", 32'(acc), 3);
        check("bp_in_ready_low", 32'(b8.in_ready), 0);
        check("bp_out_valid", 32'(b8.out_valid), 1);
        check("bp_sum", 32'(b8.out_sum), 32'(11'(8 * 17)));
        check("bp_tag", 32'(b8.out_tag), 1);
        tick();
        tick();
        check("bp_sum_held", 32'(b8.out_sum), 32'(11'(8 * 17)));
        check("bp_tag_held", 32'(b8.out_tag), 1);
        check("bp_still_3", 32'(acc), 3);
        b8.out_ready = 1;
        #1;
        check("bp_release_ready", 32'(b8.in_ready), 1);
        while (rcv < 6 && cyc < 60) begin
            b8.in_valid = (acc < 6);
            b8.in_ops   = {8{bp_byte(acc)}};
            b8.in_tag   = 4'(acc + 1);
            tick();
        end
        b8.in_valid = 0;
        check("bp_results", 32'(rcv), 6);
        check("bp_accepted_all", 32'(acc), 6);
        check("bp_extra", 32'(extra), 0);
        sb_en = 0;

        // Asynchronous reset with three sets in flight
        for (int i = 0; i < 3; i++) begin
            b8.in_valid = 1;
            b8.in_ops   = {8{8'h40}};
            b8.in_tag   = 4'(i + 1);
            @(posedge clk);
            #1;
        end
        b8.in_valid = 0;
        check("mid_pre_valid", 32'(b8.out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(b8.out_valid), 0);
        check("mid_rst_sum", 32'(b8.out_sum), 0);
        check("mid_rst_tag", 32'(b8.out_tag), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_in_ready", 32'(b8.in_ready), 1);
        stale = 0;
        repeat (6) begin
            if (b8.out_valid) stale++;
            @(posedge clk);
            #1;
        end
        check("mid_no_stale", 32'(stale), 0);

        // NUM_OPS=2: one level, latency 1
        ops2[0] = 16'hFFFF; exp2[0] = 9'h1FE;
        ops2[1] = 16'h0201; exp2[1] = 9'h003;
        for (int i = 0; i < 2; i++) begin
            b2.in_valid = 1;
            b2.in_ops   = ops2[i];
            b2.in_tag   = 4'(7 + i);
            #1;
            check("n2_in_ready", 32'(b2.in_ready), 1);
            @(posedge clk);
            #1;
            b2.in_valid = 0;
            b2.in_ops   = 'x;
            lat = 1;
            while (!b2.out_valid && lat < 10) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check("n2_latency", 32'(lat), 1);
            check("n2_sum", 32'(b2.out_sum), 32'(exp2[i]));
            check("n2_tag", 32'(b2.out_tag), 32'(7 + i));
            @(posedge clk);
            #1;
        end

        // NUM_OPS=16: four levels, latency 4, 12-bit result
        exp16[0] = 12'hFF0; tag16[0] = 4'hB;
        exp16[1] = 12'h088; tag16[1] = 4'h6;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 16; k++) ops16[k*8 +: 8] = (i == 0) ? 8'hFF : 8'(k + 1);
            b16.in_valid = 1;
            b16.in_ops   = ops16;
            b16.in_tag   = tag16[i];
            #1;
            check("n16_in_ready", 32'(b16.in_ready), 1);
            @(posedge clk);
            #1;
            b16.in_valid = 0;
            b16.in_ops   = 'x;
            lat = 1;
            while (!b16.out_valid && lat < 10) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check("n16_latency", 32'(lat), 4);
            check("n16_sum", 32'(b16.out_sum), 32'(exp16[i]));
            check("n16_tag", 32'(b16.out_tag), 32'(tag16[i]));
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder_tree_8bit_pipe.md
Name: adder_tree_8bit_pipe

Overview:
- Pipelined, throughput-1 reduction tree that sums NUM_OPS unsigned IN_W-bit operands into one exact, full-width result.
- Sits directly upstream of the accumulation/output stage in the adder-tree configuration.
- Its level-1 adders are the existing 8-bit ripple-carry adders (half_adder plus full_adder_acc cells). Each tree level is followed by one register slice, and the levels are joined by a valid/ready handshake so the tree can absorb downstream backpressure.

Parameters:
- NUM_OPS, 8, operand count; legal values 2, 4, 8, 16 (power of two); elaboration error otherwise.
- IN_W, 8, operand width; level 1 requires IN_W = 8 (8-bit RCA); elaboration error otherwise.
- TAG_W, 4, width of the sideband tag carried alongside each operand set.
- LVLS, log2(NUM_OPS), localparam: tree depth and latency in cycles.
- OUT_W, IN_W+LVLS, localparam: result width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand set present
- in_ready  output  1  tree can accept this cycle
- in_ops  input  NUM_OPS*IN_W  packed operands; op k at [k*IN_W +: IN_W]
- in_tag  input  TAG_W  sideband tag, passed through unchanged
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts
- out_sum  output  OUT_W  sum of all operands
- out_tag  output  TAG_W  tag of that operand set

Behaviour:
- Reset (async assert, sync-safe deassert):
  - All stage valid bits clear; out_valid=0, out_sum=0, out_tag=0.
  - in_ready=1 on the first cycle after deassertion.
- Level arithmetic:
  - Level L (1..LVLS) adds adjacent pairs of (IN_W+L-1)-bit values into (IN_W+L)-bit values.
  - Each adder's carry-out becomes the result MSB. No truncation, no saturation, no overflow possible.
  - Pair order: op[2i]+op[2i+1] at level 1, then the same pairwise pattern on each level's outputs.
- Level 1 uses one rca_8bit per pair (cout concatenated above sum). Levels 2..LVLS use the new rca_nbit sub-module.
- Pipeline:
  - One register slice per level: stage s holds valid_s, partial sums and tag.
  - Stage LVLS drives out_*.
  - Latency is exactly LVLS cycles from accepted input to out_valid with no stall.
- Handshake:
  - Transfer in occurs when in_valid && in_ready; transfer out occurs when out_valid && out_ready.
  - Stage s advances when !valid_s or stage s+1 advances; the last stage advances when !out_valid or out_ready.
  - in_ready = stage-1 advance condition. in_ready must not depend combinationally on in_valid.
  - A stalled stage holds data and valid unchanged.
  - While out_valid=1 and out_ready=0, out_sum and out_tag are stable.
- Capacity and throughput:
  - Capacity is LVLS operand sets, with no bubbles.
  - Sustained 1 result per cycle when out_ready is held high.
- Simultaneous events: with all stages full and out_ready=1, a new input is accepted in the same cycle a result leaves.
- in_valid deasserted mid-stream inserts a bubble that propagates; out_valid=0 for that slot.
- Reset mid-operation discards all in-flight sets; nothing is emitted after reset.
- in_ops/in_tag are ignored when in_valid=0 (X-tolerant; X must not propagate into valid bits).

Decomposition:
- Shared package adder_tree_pkg:
  - clog2 function.
  - Legal NUM_OPS check.
  - Localparams derived from NUM_OPS, IN_W and TAG_W.
  - Per-level width function IN_W+L.
- Sub-module rca_nbit (parameter W): ripple-carry adder of W-bit a and b giving W-bit sum plus cout.
  - Built as a half_adder at bit 0 followed by full_adder_acc cells.
  - Bit-exact with rca_8bit at W=8.

Test Plan:
- Default params, single set ops=1..8, tag=0x5, out_ready=1 -> out_valid exactly 3 cycles after acceptance, out_sum=36 (0x024), out_tag=0x5.
- All ops=0xFF -> out_sum=2040 (0x7F8), MSB carry path exercised; all ops=0x00 -> 0x000.
- 20 back-to-back random sets, out_ready=1 -> 20 results in order, one per cycle, each matching a reference sum; tags in order.
- out_ready=0 for 6 cycles while in_valid=1 -> exactly 3 sets accepted, in_ready=0 afterwards, out_sum/out_tag stable. Raise out_ready -> in_ready=1 in the same cycle, no loss or duplication.
- Assert rst_n low with 3 sets in flight -> out_valid=0 and out_sum=0 immediately (async). After release, in_ready=1 and no stale result appears.
- NUM_OPS=2 and NUM_OPS=16 builds -> latency 1 and 4 respectively; sixteen ops of 0xFF -> 4080 (0xFF0, 12-bit).
